// File: rtl/hc05_pkg.sv
// Shared types and constants for the HC-05 message arbiter.
// HC05_CRLF_EN selects the 12-byte frame that ends in CR/LF.
package hc05_pkg;

    typedef enum logic [1:0] {StIdle, StSend, StDone} state_e;

    localparam logic [7:0] ChF    = 8'h46;
    localparam logic [7:0] ChI    = 8'h49;
    localparam logic [7:0] ChM    = 8'h4D;
    localparam logic [7:0] ChDash = 8'h2D;
    localparam logic [7:0] ChS    = 8'h53;
    localparam logic [7:0] ChU    = 8'h55;
    localparam logic [7:0] ChHash = 8'h23;
    localparam logic [7:0] ChCr   = 8'h0D;
    localparam logic [7:0] ChLf   = 8'h0A;

    localparam int unsigned FrameLenBase = 10;
    localparam int unsigned FrameLenCrlf = 12;

`ifdef HC05_CRLF_EN
    localparam int unsigned FrameLen = FrameLenCrlf;
    localparam int unsigned PtrW     = 5;
`else
    localparam int unsigned FrameLen = FrameLenBase;
    localparam int unsigned PtrW     = 4;
`endif

endpackage

// File: rtl/hc05_frame_rom.sv
// Combinational frame lookup: byte pointer plus captured unit/index to frame byte.
// HC05_CRLF_EN adds the trailing CR and LF entries.
module hc05_frame_rom
    import hc05_pkg::*;
#(
    parameter int unsigned FRAME_BYTES = FrameLen
) (
    input  logic [PtrW-1:0] ptr,
    input  logic [7:0]      unit,
    input  logic [7:0]      idx,
    output logic [7:0]      byte_data,
    output logic            last
);

    always_comb begin
        byte_data = 8'h00;
        unique case (ptr)
            PtrW'(0):  byte_data = ChF;
            PtrW'(1):  byte_data = ChI;
            PtrW'(2):  byte_data = ChM;
            PtrW'(3):  byte_data = ChDash;
            PtrW'(4):  byte_data = unit;
            PtrW'(5):  byte_data = ChS;
            PtrW'(6):  byte_data = ChU;
            PtrW'(7):  byte_data = idx;
            PtrW'(8):  byte_data = ChDash;
            PtrW'(9):  byte_data = ChHash;
`ifdef HC05_CRLF_EN
            PtrW'(10): byte_data = ChCr;
            PtrW'(11): byte_data = ChLf;
`endif
            default:   byte_data = 8'h00;
        endcase
    end

    assign last = (ptr == PtrW'(FRAME_BYTES - 1));

endmodule

// File: rtl/hc05_msg_arbiter.sv
// Round-robin arbiter that streams "FIM-<unit>SU<idx>-#" frames to the HC-05 UART.
// HC05_CRLF_EN appends CR/LF to every frame.
module hc05_msg_arbiter
    import hc05_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned MSG_LEN = 10
) (
    input  logic                 clk,
    input  logic                 jreset,
    input  logic                 en,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [NUM_REQ*8-1:0] req_unit,
    input  logic [NUM_REQ*8-1:0] req_idx,
    output logic [NUM_REQ-1:0]   ack,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 busy,
    output logic [7:0]           byte_data,
    output logic                 byte_valid,
    input  logic                 byte_ready
);

    localparam int unsigned IdxW       = $clog2(NUM_REQ);
    localparam int unsigned FrameBytes = MSG_LEN + (FrameLen - FrameLenBase);

    state_e          state_q;
    logic [PtrW-1:0] ptr_q;
    logic [IdxW-1:0] rr_q;
    logic [IdxW-1:0] owner_q;
    logic [7:0]      unit_q;
    logic [7:0]      idx_q;

    logic [7:0]      unit_arr [NUM_REQ];
    logic [7:0]      idx_arr  [NUM_REQ];
    logic [IdxW-1:0] win;
    logic            found;
    logic [7:0]      rom_byte;
    logic            rom_last;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign unit_arr[g] = req_unit[8*g +: 8];
        assign idx_arr[g]  = req_idx[8*g +: 8];
    end

    // First pending request at or above rr_q, wrapping around.
    always_comb begin
        int unsigned k;
        logic [IdxW-1:0] k_idx;
        found = 1'b0;
        win   = '0;
        k     = 0;
        k_idx = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            k     = (32'(rr_q) + i) % NUM_REQ;
            k_idx = IdxW'(k);
            if (!found && req[k_idx]) begin
                found = 1'b1;
                win   = k_idx;
            end
        end
    end

    hc05_frame_rom #(
        .FRAME_BYTES(FrameBytes)
    ) u_rom (
        .ptr      (ptr_q),
        .unit     (unit_q),
        .idx      (idx_q),
        .byte_data(rom_byte),
        .last     (rom_last)
    );

    assign byte_data = (state_q == StSend) ? rom_byte : 8'h00;

    always_ff @(posedge clk or posedge jreset) begin
        if (jreset) begin
            state_q    <= StIdle;
            ptr_q      <= '0;
            rr_q       <= '0;
            owner_q    <= '0;
            unit_q     <= 8'h00;
            idx_q      <= 8'h00;
            grant      <= '0;
            ack        <= '0;
            busy       <= 1'b0;
            byte_valid <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    ack <= '0;
                    if (en && found) begin
                        owner_q    <= win;
                        unit_q     <= unit_arr[win];
                        idx_q      <= idx_arr[win];
                        grant      <= NUM_REQ'(1) << win;
                        busy       <= 1'b1;
                        byte_valid <= 1'b1;
                        ptr_q      <= '0;
                        state_q    <= StSend;
                    end
                end
                StSend: begin
                    if (byte_ready) begin
                        if (rom_last) begin
                            state_q    <= StDone;
                            byte_valid <= 1'b0;
                            ack        <= grant;
                            grant      <= '0;
                            busy       <= 1'b0;
                            ptr_q      <= '0;
                            rr_q       <= (owner_q == IdxW'(NUM_REQ - 1)) ? '0
                                                                          : owner_q + 1'b1;
                        end else begin
                            ptr_q <= ptr_q + 1'b1;
                        end
                    end
                end
                StDone: begin
                    ack     <= '0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_hc05_msg_arbiter.sv
// Self-checking bench for hc05_msg_arbiter: transaction-level model plus directed checks.
// Honours HC05_CRLF_EN for the expected frame length and trailer.
module tb_hc05_msg_arbiter;

    localparam int NUM_REQ = 4;
`ifdef HC05_CRLF_EN
    localparam int FL = 12;
`else
    localparam int FL = 10;
`endif

    logic                 clk = 1'b0;
    logic                 jreset = 1'b1;
    logic                 en = 1'b0;
    logic [NUM_REQ-1:0]   req = '0;
    logic [NUM_REQ*8-1:0] req_unit = '0;
    logic [NUM_REQ*8-1:0] req_idx = '0;
    logic [NUM_REQ-1:0]   ack;
    logic [NUM_REQ-1:0]   grant;
    logic                 busy;
    logic [7:0]           byte_data;
    logic                 byte_valid;
    logic                 byte_ready = 1'b1;

    int checks = 0;
    int errors = 0;

    hc05_msg_arbiter #(
        .NUM_REQ(NUM_REQ),
        .MSG_LEN(10)
    ) dut (
        .clk       (clk),
        .jreset    (jreset),
        .en        (en),
        .req       (req),
        .req_unit  (req_unit),
        .req_idx   (req_idx),
        .ack       (ack),
        .grant     (grant),
        .busy      (busy),
        .byte_data (byte_data),
        .byte_valid(byte_valid),
        .byte_ready(byte_ready)
    );

    always #5 clk = ~clk;

    // Backpressure pattern driver.
    bit bp_on = 1'b0;
    bit bp_pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int bp_cnt = 0;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (bp_on) begin
                byte_ready = bp_pat[bp_cnt];
                bp_cnt = (bp_cnt + 1) % 4;
            end else begin
                byte_ready = 1'b1;
            end
        end
    end

    // Model: the frame of the current owner is a queue of bytes still to be sent.
    logic [7:0] mq[$];
    bit m_done = 1'b0;
    int m_owner = 0;
    int m_rr = 0;

    initial begin
        forever begin
            @(posedge clk or posedge jreset);
            if (jreset) begin
                mq.delete();
                m_done = 1'b0;
                m_rr = 0;
                m_owner = 0;
            end else if (mq.size() != 0) begin
                if (byte_ready) begin
                    void'(mq.pop_front());
                    if (mq.size() == 0) begin
                        m_done = 1'b1;
                        m_rr = (m_owner + 1) % NUM_REQ;
                    end
                end
            end else if (m_done) begin
                m_done = 1'b0;
            end else if (en && req != 0) begin
                bit got;
                got = 1'b0;
                for (int i = 0; i < NUM_REQ; i++) begin
                    int k;
                    k = (m_rr + i) % NUM_REQ;
                    if (!got && req[k]) begin
                        got = 1'b1;
                        m_owner = k;
                    end
                end
                mq.push_back("F"); mq.push_back("I"); mq.push_back("M"); mq.push_back("-");
                mq.push_back(req_unit[8*m_owner +: 8]);
                mq.push_back("S"); mq.push_back("U");
                mq.push_back(req_idx[8*m_owner +: 8]);
                mq.push_back("-"); mq.push_back("#");
`ifdef HC05_CRLF_EN
                mq.push_back(8'h0D); mq.push_back(8'h0A);
`endif
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (!jreset) begin
                logic               e_v;
                logic [7:0]         e_d;
                logic [NUM_REQ-1:0] e_g;
                logic [NUM_REQ-1:0] e_a;
                e_v = (mq.size() != 0);
                e_d = e_v ? mq[0] : 8'h00;
                e_g = e_v ? NUM_REQ'(1) << m_owner : '0;
                e_a = m_done ? NUM_REQ'(1) << m_owner : '0;
                checks++;
                if (byte_valid !== e_v || byte_data !== e_d || busy !== e_v ||
                    grant !== e_g || ack !== e_a) begin
                    errors++;
                    $display("FAIL cycle_model t=%0t got v=%b d=%h busy=%b grant=%b ack=%b exp v=%b d=%h busy=%b grant=%b ack=%b",
                             $time, byte_valid, byte_data, busy, grant, ack,
                             e_v, e_d, e_v, e_g, e_a);
                end
            end
        end
    end

    // Transfer and ack logs for the directed checks.
    logic [7:0] log_q[$];
    int log_cyc[$];
    int ack_log[$];
    int cyc = 0;
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            if (!jreset) begin
                if (byte_valid && byte_ready) begin
                    log_q.push_back(byte_data);
                    log_cyc.push_back(cyc);
                end
                for (int i = 0; i < NUM_REQ; i++) if (ack[i]) ack_log.push_back(i);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(string name, int got, int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic wait_acks(int n, int budget);
        int t;
        t = 0;
        while (ack_log.size() < n && t < budget) begin
            tick();
            t++;
        end
        checks++;
        if (ack_log.size() < n) begin
            errors++;
            $display("FAIL wait_acks got=%0d exp=%0d", ack_log.size(), n);
        end
    endtask

    task automatic check_frame(string name, string s);
        logic [7:0] e [$];
        int bad;
        for (int i = 0; i < s.len(); i++) e.push_back(s[i]);
`ifdef HC05_CRLF_EN
        e.push_back(8'h0D); e.push_back(8'h0A);
`endif
        bad = -1;
        for (int i = 0; i < e.size(); i++) begin
            if (bad < 0 && (i >= log_q.size() || log_q[i] !== e[i])) bad = i;
        end
        checks++;
        if (bad >= 0 || log_q.size() != e.size()) begin
            errors++;
            $display("FAIL %s first bad byte %0d got size=%0d exp size=%0d", name, bad,
                     log_q.size(), e.size());
        end
    endtask

    task automatic clear_logs();
        log_q.delete();
        log_cyc.delete();
        ack_log.delete();
    endtask

    initial begin
        string units;
        repeat (3) tick();
        check("reset_valid", int'(byte_valid), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_grant", int'(grant), 0);
        check("reset_ack", int'(ack), 0);
        check("reset_data", int'(byte_data), 0);
        jreset = 1'b0;
        en = 1'b1;
        tick();

        // Round-robin contention, starting from rr=0.
        req_unit = {"D", "-", "B", "A"};
        req_idx = {"3", "2", "1", "0"};
        clear_logs();
        req = 4'b1011;
        wait_acks(4, 200);
        req = '0;
        check("rr_ack0", ack_log.size() > 0 ? ack_log[0] : -1, 0);
        check("rr_ack1", ack_log.size() > 1 ? ack_log[1] : -1, 1);
        check("rr_ack2", ack_log.size() > 2 ? ack_log[2] : -1, 3);
        check("rr_ack3", ack_log.size() > 3 ? ack_log[3] : -1, 0);
        check("rr_len", log_q.size(), 4 * FL);
        units = "ABDA";
        for (int m = 0; m < 4; m++)
            check("rr_unit", log_q.size() > m * FL + 4 ? int'(log_q[m * FL + 4]) : -1,
                  int'(units[m]));
        repeat (3) tick();

        // Single requester, ready always high.
        req_unit[7:0] = "E";
        req_idx[7:0] = "3";
        clear_logs();
        req = 4'b0001;
        wait_acks(1, 50);
        req = '0;
        check_frame("single_frame", "FIM-ESU3-#");
        check("single_ack", ack_log.size() > 0 ? ack_log[0] : -1, 0);
        check("single_consecutive",
              log_cyc.size() == FL ? log_cyc[FL - 1] - log_cyc[0] : -1, FL - 1);
        repeat (3) tick();

        // Backpressure.
        clear_logs();
        bp_on = 1'b1;
        req = 4'b0001;
        wait_acks(1, 100);
        req = '0;
        bp_on = 1'b0;
        check_frame("bp_frame", "FIM-ESU3-#");
        check("bp_count", log_q.size(), FL);
        repeat (3) tick();

        // Asynchronous reset after the 5th transfer.
        clear_logs();
        req = 4'b0001;
        for (int t = 0; t < 50 && log_q.size() < 5; t++) tick();
        check("mid_transfers", log_q.size(), 5);
        #2;
        jreset = 1'b1;
        #1;
        check("async_valid", int'(byte_valid), 0);
        check("async_busy", int'(busy), 0);
        check("async_grant", int'(grant), 0);
        check("async_data", int'(byte_data), 0);
        tick();
        jreset = 1'b0;
        clear_logs();
        wait_acks(1, 50);
        req = '0;
        check("restart_first", log_q.size() > 0 ? int'(log_q[0]) : -1, int'("F"));
        check_frame("restart_frame", "FIM-ESU3-#");
        repeat (3) tick();

        // Enable gating.
        req_unit[23:16] = "C";
        req_idx[23:16] = "7";
        clear_logs();
        en = 1'b0;
        req = 4'b0100;
        begin
            int seen;
            seen = 0;
            for (int t = 0; t < 100; t++) begin
                tick();
                if (byte_valid) seen++;
            end
            check("gate_no_valid", seen, 0);
        end
        en = 1'b1;
        wait_acks(1, 50);
        req = '0;
        check_frame("gate_frame", "FIM-CSU7-#");
        check("gate_ack", ack_log.size() > 0 ? ack_log[0] : -1, 2);
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1);
    end

endmodule

// File: doc/hc05_msg_arbiter.md
Name: hc05_msg_arbiter

Overview:
Shares the single HC-05 UART byte transmitter between NUM_REQ message sources (supply units, status reporters).
- Picks one pending requester round-robin and latches its unit and index characters.
- Streams the framed ASCII message "FIM-" unit "SU" index "-#" to the UART byte transmitter over a valid/ready handshake.
- Pulses an acknowledge to the winning requester once the last byte is accepted.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- MSG_LEN, 10, base frame length in bytes (fixed by frame format; not user-overridable in practice).

Ports:
- clk  in  1  system clock (50 MHz).
- jreset  in  1  asynchronous, active-high reset.
- en  in  1  start enable; low blocks new arbitration, an in-flight message still completes.
- req  in  NUM_REQ  per-requester level request; hold until ack.
- req_unit  in  NUM_REQ*8  ASCII unit char per requester (slice k = bits 8k+7:8k), e.g. "E", "C".
- req_idx  in  NUM_REQ*8  ASCII index digit per requester, e.g. "3".
- ack  out  NUM_REQ  one-cycle pulse to the served requester.
- grant  out  NUM_REQ  one-hot current owner; zero when idle.
- busy  out  1  high while a message is owned.
- byte_data  out  8  byte to UART transmitter.
- byte_valid  out  1  byte_data valid.
- byte_ready  in  1  UART transmitter can accept a byte.

Behaviour:
- Reset values, applied immediately on jreset=1 regardless of clk, including mid-message with no partial-frame completion:
  - outputs: ack=0, grant=0, busy=0, byte_valid=0, byte_data=8'h00;
  - internal: state=IDLE, byte pointer ptr=0, round-robin pointer rr=0.
- IDLE state:
  - If en=1 and req!=0, choose the first set req bit searching upward from rr, wrapping modulo NUM_REQ.
  - Capture that requester's req_unit/req_idx into unit_q/idx_q, set grant one-hot and busy=1, go to SEND.
  - Otherwise stay in IDLE.
- SEND state:
  - byte_valid=1 from the first SEND cycle; the first byte is valid one cycle after the cycle in which req was sampled.
  - byte_data = frame[ptr]; frame = "F","I","M","-",unit_q,"S","U",idx_q,"-","#".
  - A transfer occurs on a cycle with byte_valid&byte_ready; ptr increments by 1.
  - While byte_ready=0, byte_valid and byte_data hold stable.
  - On transfer of the last byte, go to DONE with byte_valid=0 next cycle.
- DONE state, one cycle:
  - ack[g]=1; grant=0, busy=0, ptr=0.
  - rr=(g+1) mod NUM_REQ.
  - Return to IDLE. A new grant is possible the following cycle, so there is at least one idle cycle between messages.
- Request and enable changes while busy:
  - Requester dropping req during SEND: ignored; the message completes and ack is still pulsed.
  - Changes to req_unit/req_idx after capture do not affect the current frame.
  - en falling mid-message: no effect until IDLE.
- ptr is 4 bits wide (5 bits if HC05_CRLF_EN is defined). It never exceeds the last index, so there is no wrap.
- Simultaneous requests: a strict round-robin rotation guarantees that no requester waits more than NUM_REQ-1 messages.

Optional Feature:
- Macro: HC05_CRLF_EN.
- Defined: the frame is extended to 12 bytes, appending 8'h0D then 8'h0A after "#"; DONE follows the 8'h0A transfer.
- Undefined: the frame is exactly 10 bytes ending in "#"; no CR/LF logic is synthesised.

Decomposition:
- Shared package hc05_pkg holds:
  - state enum typedef (IDLE, SEND, DONE);
  - ASCII constants for "F","I","M","-","S","U","#", CR and LF;
  - frame length localparams for both feature settings.
- One sub-module, hc05_frame_rom: purely combinational mapping (ptr, unit_q, idx_q) to byte_data, and a last-byte flag. The arbiter/FSM stays in hc05_msg_arbiter.

Test Plan:
- Single requester: req=4'b0001, req_unit[7:0]="E", req_idx[7:0]="3", byte_ready tied 1.
  - Bytes "FIM-ESU3-#" are accepted on 10 consecutive cycles.
  - ack[0] pulses once on the cycle after "#".
- Backpressure: same as the single-requester case with byte_ready toggling 1,0,0,1.
  - byte_data stays constant across ready=0 cycles; no byte is skipped or duplicated; total transfers = 10.
- Round-robin contention: req=4'b1011 held, each unit char distinct ("A","B","-","D").
  - Grant order is 0,1,3,0, with ack pulses in that order.
  - Requester 2 is never granted.
- Reset mid-message: assert jreset asynchronously after the 5th transfer.
  - byte_valid, busy and grant drop without waiting for clk.
  - After release with req=4'b0001, the frame restarts at "F".
- Enable gating: en=0 with req=4'b0100.
  - No byte_valid for 100 cycles.
  - Raise en: the message "FIM-" unit "SU" index "-#" for requester 2 follows.
- With HC05_CRLF_EN defined, the single-requester case yields 12 transfers ending 8'h0D, 8'h0A, and ack after 8'h0A.
